// File: rtl/id_ex_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_reg_pkg
// Purpose  : Shared decode constants and the ID/EX control bundle type.
// Revision : 1.0 - initial release
// ============================================================================
package id_ex_stage_reg_pkg;

  // ALU op classes produced by decode
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  localparam int CTRL_W = 8;

  // Control bundle carried from ID into EX (CTRL_W bits wide)
  typedef struct packed {
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       aluSrc;
    logic       branch;
    logic [1:0] aluOp;
  } ctrl_t;

  // All-zero control word: a bubble has no architectural side effects
  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_reg_if
// Purpose  : ID-side inputs, EX-side outputs and hazard/perf views of the
//            ID/EX pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
interface id_ex_stage_reg_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  // pipeline control
  logic             flush;
  logic             hold;
  logic             control_select;
  // ID side
  logic             id_valid;
  logic             id_regWrite, id_memRead, id_memWrite, id_memToReg, id_aluSrc, id_branch;
  logic [1:0]       id_aluOp;
  logic [2:0]       id_funct3;
  logic             id_funct7b5;
  logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  // EX side
  logic             ex_valid;
  logic             ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc, ex_branch;
  logic [1:0]       ex_aluOp;
  logic [2:0]       ex_funct3;
  logic             ex_funct7b5;
  logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  // hazard-unit view and performance counters
  logic             id_ex_memRead;
  logic [4:0]       id_ex_rd;
  logic [CNT_W-1:0] bubble_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output flush, hold, control_select, id_valid,
           id_regWrite, id_memRead, id_memWrite, id_memToReg, id_aluSrc, id_branch,
           id_aluOp, id_funct3, id_funct7b5, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd,
    input  ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc,
           ex_branch, ex_aluOp, ex_funct3, ex_funct7b5, ex_pc, ex_rs1_data, ex_rs2_data,
           ex_imm, ex_rs1, ex_rs2, ex_rd, id_ex_memRead, id_ex_rd, bubble_count, flush_count
  );

  modport slave (
    input  flush, hold, control_select, id_valid,
           id_regWrite, id_memRead, id_memWrite, id_memToReg, id_aluSrc, id_branch,
           id_aluOp, id_funct3, id_funct7b5, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd,
    output ex_valid, ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc,
           ex_branch, ex_aluOp, ex_funct3, ex_funct7b5, ex_pc, ex_rs1_data, ex_rs2_data,
           ex_imm, ex_rs1, ex_rs2, ex_rd, id_ex_memRead, id_ex_rd, bubble_count, flush_count
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage_reg_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Event counter that sticks at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             inc,
  output logic      [CNT_W-1:0] count
);
  import id_ex_stage_reg_pkg::*;

  logic [CNT_W-1:0] r_count;

  // Count events, holding at the maximum value once reached
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage_reg
// Purpose  : ID/EX pipeline register with bubble/flush insertion, stall hold
//            and saturating bubble/flush event counters.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  wire logic        clk,
  input  wire logic        reset,
  id_ex_stage_reg_if.slave bus
);
  import id_ex_stage_reg_pkg::*;

  ctrl_t           w_id_ctrl;
  logic            w_load;
  logic            w_kill;
  logic            w_bubble_inc;

  ctrl_t           r_ctrl;
  logic            r_valid;
  logic [2:0]      r_funct3;
  logic            r_funct7b5;
  logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [4:0]      r_rs1, r_rs2, r_rd;

  assign w_id_ctrl = {bus.id_regWrite, bus.id_memRead, bus.id_memWrite, bus.id_memToReg,
                      bus.id_aluSrc, bus.id_branch, bus.id_aluOp};

  // Flush overrides a stall; otherwise a stall freezes the stage
  assign w_load       = bus.flush | ~bus.hold;
  // Flush and hazard bubble both squash controls and rd so nothing retires
  assign w_kill       = bus.flush | ~bus.control_select;
  // A bubble counts only when it is actually written and not superseded by flush
  assign w_bubble_inc = ~bus.flush & ~bus.hold & ~bus.control_select;

  // Stage register: data always follows ID on a write, controls squashed on kill
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl     <= BUBBLE_CTRL;
      r_valid    <= 1'b0;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
    end else if (w_load) begin
      r_funct3   <= bus.id_funct3;
      r_funct7b5 <= bus.id_funct7b5;
      r_pc       <= bus.id_pc;
      r_rs1_data <= bus.id_rs1_data;
      r_rs2_data <= bus.id_rs2_data;
      r_imm      <= bus.id_imm;
      r_rs1      <= bus.id_rs1;
      r_rs2      <= bus.id_rs2;
      if (w_kill) begin
        r_ctrl  <= BUBBLE_CTRL;
        r_valid <= 1'b0;
        r_rd    <= '0;
      end else begin
        r_ctrl  <= w_id_ctrl;
        r_valid <= bus.id_valid;
        r_rd    <= bus.id_rd;
      end
    end
  end

  assign bus.ex_valid      = r_valid;
  assign bus.ex_regWrite   = r_ctrl.regWrite;
  assign bus.ex_memRead    = r_ctrl.memRead;
  assign bus.ex_memWrite   = r_ctrl.memWrite;
  assign bus.ex_memToReg   = r_ctrl.memToReg;
  assign bus.ex_aluSrc     = r_ctrl.aluSrc;
  assign bus.ex_branch     = r_ctrl.branch;
  assign bus.ex_aluOp      = r_ctrl.aluOp;
  assign bus.ex_funct3     = r_funct3;
  assign bus.ex_funct7b5   = r_funct7b5;
  assign bus.ex_pc         = r_pc;
  assign bus.ex_rs1_data   = r_rs1_data;
  assign bus.ex_rs2_data   = r_rs2_data;
  assign bus.ex_imm        = r_imm;
  assign bus.ex_rs1        = r_rs1;
  assign bus.ex_rs2        = r_rs2;
  assign bus.ex_rd         = r_rd;
  assign bus.id_ex_memRead = r_ctrl.memRead;
  assign bus.id_ex_rd      = r_rd;

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_bubble_inc),
    .count (bus.bubble_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.flush),
    .count (bus.flush_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage_reg
// Purpose  : Directed and randomized checks of id_ex_stage_reg against a
//            behavioural model of the stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage_reg;
  import id_ex_stage_reg_pkg::*;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 16;
  localparam int CNT_W_S = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg_if #(.XLEN(XLEN), .CNT_W(CNT_W))   bus ();
  id_ex_stage_reg_if #(.XLEN(XLEN), .CNT_W(CNT_W_S)) bus_s ();

  id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(CNT_W))   dut   (.clk(clk), .reset(reset), .bus(bus));
  id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(CNT_W_S)) dut_s (.clk(clk), .reset(reset), .bus(bus_s));

  // small-counter instance sees identical stimulus
  assign bus_s.flush = bus.flush;           assign bus_s.hold = bus.hold;
  assign bus_s.control_select = bus.control_select;
  assign bus_s.id_valid = bus.id_valid;     assign bus_s.id_regWrite = bus.id_regWrite;
  assign bus_s.id_memRead = bus.id_memRead; assign bus_s.id_memWrite = bus.id_memWrite;
  assign bus_s.id_memToReg = bus.id_memToReg; assign bus_s.id_aluSrc = bus.id_aluSrc;
  assign bus_s.id_branch = bus.id_branch;   assign bus_s.id_aluOp = bus.id_aluOp;
  assign bus_s.id_funct3 = bus.id_funct3;   assign bus_s.id_funct7b5 = bus.id_funct7b5;
  assign bus_s.id_pc = bus.id_pc;           assign bus_s.id_rs1_data = bus.id_rs1_data;
  assign bus_s.id_rs2_data = bus.id_rs2_data; assign bus_s.id_imm = bus.id_imm;
  assign bus_s.id_rs1 = bus.id_rs1;         assign bus_s.id_rs2 = bus.id_rs2;
  assign bus_s.id_rd = bus.id_rd;

  // ---------------- behavioural model of the EX-side view ----------------
  logic        m_valid, m_regWrite, m_memRead, m_memWrite, m_memToReg, m_aluSrc, m_branch;
  logic [1:0]  m_aluOp;
  logic [2:0]  m_funct3;
  logic        m_funct7b5;
  logic [31:0] m_pc, m_rs1_data, m_rs2_data, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  int          m_bub, m_fl, m_bub_s, m_fl_s;

  function automatic int sat_inc(int v, int w);
    return (v >= (1 << w) - 1) ? v : v + 1;
  endfunction

  task automatic model_reset();
    {m_valid, m_regWrite, m_memRead, m_memWrite, m_memToReg, m_aluSrc, m_branch} = '0;
    m_aluOp = 0; m_funct3 = 0; m_funct7b5 = 0;
    m_pc = 0; m_rs1_data = 0; m_rs2_data = 0; m_imm = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_bub = 0; m_fl = 0; m_bub_s = 0; m_fl_s = 0;
  endtask

  // What an instruction carries into EX regardless of being squashed
  task automatic model_take_data();
    m_funct3 = bus.id_funct3; m_funct7b5 = bus.id_funct7b5;
    m_pc = bus.id_pc; m_rs1_data = bus.id_rs1_data; m_rs2_data = bus.id_rs2_data;
    m_imm = bus.id_imm; m_rs1 = bus.id_rs1; m_rs2 = bus.id_rs2;
  endtask

  task automatic model_squash();
    {m_valid, m_regWrite, m_memRead, m_memWrite, m_memToReg, m_aluSrc, m_branch} = '0;
    m_aluOp = 0; m_rd = 0;
  endtask

  task automatic model_edge();
    if (bus.flush) begin
      model_take_data(); model_squash();
      m_fl = sat_inc(m_fl, CNT_W); m_fl_s = sat_inc(m_fl_s, CNT_W_S);
    end else if (bus.hold) begin
      // stage frozen, nothing counted
    end else if (!bus.control_select) begin
      model_take_data(); model_squash();
      m_bub = sat_inc(m_bub, CNT_W); m_bub_s = sat_inc(m_bub_s, CNT_W_S);
    end else begin
      model_take_data();
      m_valid = bus.id_valid; m_regWrite = bus.id_regWrite; m_memRead = bus.id_memRead;
      m_memWrite = bus.id_memWrite; m_memToReg = bus.id_memToReg; m_aluSrc = bus.id_aluSrc;
      m_branch = bus.id_branch; m_aluOp = bus.id_aluOp; m_rd = bus.id_rd;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(string ctx);
    check({ctx, ".valid"},    64'(bus.ex_valid),    64'(m_valid));
    check({ctx, ".regWrite"}, 64'(bus.ex_regWrite), 64'(m_regWrite));
    check({ctx, ".memRead"},  64'(bus.ex_memRead),  64'(m_memRead));
    check({ctx, ".memWrite"}, 64'(bus.ex_memWrite), 64'(m_memWrite));
    check({ctx, ".memToReg"}, 64'(bus.ex_memToReg), 64'(m_memToReg));
    check({ctx, ".aluSrc"},   64'(bus.ex_aluSrc),   64'(m_aluSrc));
    check({ctx, ".branch"},   64'(bus.ex_branch),   64'(m_branch));
    check({ctx, ".aluOp"},    64'(bus.ex_aluOp),    64'(m_aluOp));
    check({ctx, ".funct3"},   64'(bus.ex_funct3),   64'(m_funct3));
    check({ctx, ".funct7b5"}, 64'(bus.ex_funct7b5), 64'(m_funct7b5));
    check({ctx, ".pc"},       64'(bus.ex_pc),       64'(m_pc));
    check({ctx, ".rs1_data"}, 64'(bus.ex_rs1_data), 64'(m_rs1_data));
    check({ctx, ".rs2_data"}, 64'(bus.ex_rs2_data), 64'(m_rs2_data));
    check({ctx, ".imm"},      64'(bus.ex_imm),      64'(m_imm));
    check({ctx, ".rs1"},      64'(bus.ex_rs1),      64'(m_rs1));
    check({ctx, ".rs2"},      64'(bus.ex_rs2),      64'(m_rs2));
    check({ctx, ".rd"},       64'(bus.ex_rd),       64'(m_rd));
    check({ctx, ".hz_memRead"}, 64'(bus.id_ex_memRead), 64'(m_memRead));
    check({ctx, ".hz_rd"},    64'(bus.id_ex_rd),    64'(m_rd));
    check({ctx, ".bubbles"},  64'(bus.bubble_count), 64'(m_bub));
    check({ctx, ".flushes"},  64'(bus.flush_count),  64'(m_fl));
    check({ctx, ".bubbles4"}, 64'(bus_s.bubble_count), 64'(m_bub_s));
    check({ctx, ".flushes4"}, 64'(bus_s.flush_count),  64'(m_fl_s));
  endtask

  // Advance one edge with current inputs, then compare 1 ns after the edge
  task automatic step(string ctx);
    if (reset) model_reset(); else model_edge();
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic rand_id();
    bus.id_valid = 1'($urandom);     bus.id_regWrite = 1'($urandom);
    bus.id_memRead = 1'($urandom);   bus.id_memWrite = 1'($urandom);
    bus.id_memToReg = 1'($urandom);  bus.id_aluSrc = 1'($urandom);
    bus.id_branch = 1'($urandom);    bus.id_aluOp = 2'($urandom);
    bus.id_funct3 = 3'($urandom);    bus.id_funct7b5 = 1'($urandom);
    bus.id_pc = $urandom;            bus.id_rs1_data = $urandom;
    bus.id_rs2_data = $urandom;      bus.id_imm = $urandom;
    bus.id_rs1 = 5'($urandom);       bus.id_rs2 = 5'($urandom);
    bus.id_rd = 5'($urandom);
  endtask

  // ctl = {regWrite, memRead, memWrite, memToReg, aluSrc, branch}
  task automatic set_instr(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm, input logic [2:0] f3,
                           input logic f7, input logic [5:0] ctl, input logic [1:0] aluop);
    bus.id_valid = 1'b1;
    {bus.id_regWrite, bus.id_memRead, bus.id_memWrite, bus.id_memToReg,
     bus.id_aluSrc, bus.id_branch} = ctl;
    bus.id_aluOp = aluop; bus.id_funct3 = f3; bus.id_funct7b5 = f7;
    bus.id_pc = pc; bus.id_rd = rd; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_imm = imm;
    bus.id_rs1_data = 32'h1000 + 32'(rs1); bus.id_rs2_data = 32'h2000 + 32'(rs2);
  endtask

  initial begin
    reset = 1'b1;
    bus.flush = 1'b0; bus.hold = 1'b0; bus.control_select = 1'b1;
    rand_id();
    model_reset();

    // 1. reset held for three edges with live ID inputs
    for (int i = 0; i < 3; i++) begin
      rand_id();
      step("reset");
    end
    reset = 1'b0;

    // lw x5, 8(x1)
    set_instr(32'h100, 5'd5, 5'd1, 5'd0, 32'd8, 3'b010, 1'b0, 6'b110110, ALUOP_ADD);
    step("lw");
    check("lw.memRead_const", 64'(bus.ex_memRead), 64'd1);
    check("lw.rd_const",      64'(bus.ex_rd),      64'd5);
    check("lw.imm_const",     64'(bus.ex_imm),     64'd8);

    // 2. load-use: add x6,x5,x2 held in ID while hazard unit bubbles
    set_instr(32'h104, 5'd6, 5'd5, 5'd2, 32'd0, 3'b000, 1'b0, 6'b100000, ALUOP_R);
    bus.control_select = 1'b0;
    step("bubble");
    check("bubble.regWrite_const", 64'(bus.ex_regWrite), 64'd0);
    check("bubble.rd_const",       64'(bus.ex_rd),       64'd0);
    check("bubble.valid_const",    64'(bus.ex_valid),    64'd0);
    check("bubble.count_const",    64'(bus.bubble_count), 64'd1);
    bus.control_select = 1'b1;
    step("add");
    check("add.rd_const",       64'(bus.ex_rd),       64'd6);
    check("add.regWrite_const", 64'(bus.ex_regWrite), 64'd1);

    // 3. flush coinciding with a hazard bubble counts as a flush only
    bus.flush = 1'b1; bus.control_select = 1'b0;
    step("flush_cs0");
    check("flush.count_const",  64'(bus.flush_count),  64'd1);
    check("flush.bubble_const", 64'(bus.bubble_count), 64'd1);
    check("flush.valid_const",  64'(bus.ex_valid),     64'd0);
    bus.flush = 1'b0; bus.control_select = 1'b1;
    step("after_flush");

    // 4. hold for two edges with changing ID and a pending bubble request
    bus.hold = 1'b1; bus.control_select = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_id();
      step("hold");
      check("hold.pc_const",     64'(bus.ex_pc),        64'h104);
      check("hold.bubble_const", 64'(bus.bubble_count), 64'd1);
    end
    bus.hold = 1'b0; bus.control_select = 1'b1;

    // 5. 20 consecutive bubbles: the 4-bit counter must stop at 15
    bus.control_select = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rand_id();
      step("bubble_run");
    end
    check("sat4.bubble_const", 64'(bus_s.bubble_count), 64'd15);
    check("sat16.bubble_const", 64'(bus.bubble_count), 64'd21);
    bus.control_select = 1'b1;

    // randomized mix of flush / hold / bubble / load
    for (int i = 0; i < 400; i++) begin
      rand_id();
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.hold = ($urandom_range(0, 6) == 0);
      bus.control_select = ($urandom_range(0, 4) != 0);
      step("random");
    end
    bus.flush = 1'b0; bus.hold = 1'b0; bus.control_select = 1'b1;

    // 6. asynchronous reset between edges while a valid instruction is in EX
    set_instr(32'h200, 5'd7, 5'd3, 5'd4, 32'd12, 3'b000, 1'b0, 6'b100010, ALUOP_ADD);
    step("pre_async");
    check("pre_async.valid_const", 64'(bus.ex_valid), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    check("async.valid_const", 64'(bus.ex_valid), 64'd0);
    check("async.rd_const",    64'(bus.ex_rd),    64'd0);
    #1;
    reset = 1'b0;
    set_instr(32'h204, 5'd9, 5'd1, 5'd2, 32'd4, 3'b000, 1'b0, 6'b100010, ALUOP_ADD);
    step("post_reset");
    check("post_reset.rd_const", 64'(bus.ex_rd), 64'd9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
